fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 162 ++++++++++++++++
 tb/tb_fft_out_reorder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// Ping-pong bit-reversal reorder buffer: FFT results arrive in bit-reversed order, leave in natural order.
// Optional build macro FFT_REORDER_MAG_EN replaces {0,I,Q} output with I*I + Q*Q.
//
// state   | meaning
// R_IDLE  | read bank not full, nothing to send
// R_FETCH | RAM read of bin 0 issued, output register loads at the next edge
// R_HOLD  | output register valid, waiting for out_ready
module fft_out_reorder #(
    parameter int N          = 64,
    parameter int DATA_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [2*DATA_WIDTH-1:0]   in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [2*DATA_WIDTH:0]     out_data,
    output logic [ADDR_WIDTH-1:0]     out_index,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      frame_err
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int OUT_W  = 2 * DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_HOLD} rd_state_t;

    rd_state_t             rd_state;
    logic [WORD_W-1:0]     mem [0:2*N-1];
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  in_fire;
    logic                  wr_end;
    logic                  rd_release;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_W-1:0]     rd_word;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] fmt(input logic [WORD_W-1:0] w);
`ifdef FFT_REORDER_MAG_EN
        logic [OUT_W-1:0] i_ext;
        logic [OUT_W-1:0] q_ext;
        i_ext = {{(DATA_WIDTH+1){w[WORD_W-1]}}, w[WORD_W-1:DATA_WIDTH]};
        q_ext = {{(DATA_WIDTH+1){w[DATA_WIDTH-1]}}, w[DATA_WIDTH-1:0]};
        return i_ext * i_ext + q_ext * q_ext;
`else
        return {1'b0, w};
`endif
    endfunction

    assign in_ready   = ~full[wr_bank];
    assign in_fire    = in_valid & in_ready;
    assign wr_end     = in_fire & (wr_cnt == LAST_ADDR);
    assign rd_release = (rd_state == R_HOLD) & out_ready & out_last;

    // In R_HOLD the next bin is read during the handshake cycle so a steady out_ready streams without gaps.
    always_comb begin
        rd_addr = '0;
        if (rd_state == R_HOLD) begin
            rd_addr = out_index + ADDR_WIDTH'(1);
        end
        rd_word = mem[{rd_bank, rd_addr}];
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (in_fire) begin
                if (wr_cnt == LAST_ADDR) begin
                    wr_cnt    <= '0;
                    wr_bank   <= ~wr_bank;
                    frame_err <= ~in_last;
                end else if (in_last) begin
                    wr_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Set and clear never hit the same bank: a bank being written is empty, a bank being read is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            if (wr_end) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_release) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    out_data  <= fmt(rd_word);
                    out_index <= '0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    rd_state  <= R_HOLD;
                end
                R_HOLD: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_bank   <= ~rd_bank;
                            rd_state  <= full[~rd_bank] ? R_FETCH : R_IDLE;
                        end else begin
                            out_data  <= fmt(rd_word);
                            out_index <= rd_addr;
                            out_last  <= (rd_addr == LAST_ADDR);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder (N=8, DATA_WIDTH=8); frame-level queue model plus directed sequences.
module tb_fft_out_reorder;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int WW = 16;
    localparam int OW = 17;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [WW-1:0] in_data   = '0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          frame_err;

    int vectors     = 0;
    int miscompares = 0;

    fft_out_reorder #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    typedef struct packed {
        logic [OW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } out_t;

    typedef struct {
        logic [7:0] in_q;
        logic [7:0] exp_q;
        logic [2:0] exp_idx;
        logic       exp_last;
    } vec_t;

    out_t          exp_q[$];
    out_t          exp_e;
    out_t          held;
    logic [WW-1:0] mframe [N];
    int            mk        = 0;
    logic          err_pend  = 1'b0;
    logic          hold_prev = 1'b0;
    vec_t          tbl [N];
    int            exp_seq [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    bit            done      = 1'b0;

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            if ((k & (1 << b)) != 0) r += 1 << (AW - 1 - b);
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] fmt_model(input logic [WW-1:0] w);
`ifdef FFT_REORDER_MAG_EN
        int i;
        int q;
        i = int'($signed(w[15:8]));
        q = int'($signed(w[7:0]));
        return OW'(i * i + q * q);
`else
        return {1'b0, w};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WW-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(name, exp_q.size(), 0);
    endtask

    // Frame-level reference: collect accepted words, on commit emit them in natural order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mk        = 0;
            err_pend  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            check("frame_err", frame_err, err_pend);
            err_pend = 1'b0;
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_word", {out_data, out_index, out_last}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got index %0d data %0d, expected no output", out_index, out_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_word", {out_data, out_index, out_last}, exp_e);
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = {out_data, out_index, out_last};
            if (in_valid && in_ready) begin
                mframe[mk] = in_data;
                if (mk == N - 1) begin
                    for (int p = 0; p < N; p++) begin
                        exp_q.push_back({fmt_model(mframe[brev(p)]), AW'(p), (p == N - 1)});
                    end
                    err_pend = !in_last;
                    mk = 0;
                end else if (in_last) begin
                    err_pend = 1'b1;
                    mk = 0;
                end else begin
                    mk++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tbl[i].in_q     = 8'(i);
            tbl[i].exp_q    = 8'(exp_seq[i]);
            tbl[i].exp_idx  = 3'(i);
            tbl[i].exp_last = (i == N - 1);
        end

        // reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // bit-reversal order and first-output latency
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send({8'd0, tbl[i].in_q}, i == N - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("latency_e0", out_valid, 0);
        @(negedge clk);
        check("latency_e1", out_valid, 0);
        @(negedge clk);
        check("latency_e2", out_valid, 1);
        for (int i = 0; i < N; i++) begin
            check("order_valid", out_valid, 1);
            check("order_data", out_data, fmt_model({8'd0, tbl[i].exp_q}));
            check("order_index", out_index, tbl[i].exp_idx);
            check("order_last", out_last, tbl[i].exp_last);
            if (i < N - 1) @(negedge clk);
        end
        tick();
        drain("drain_order");

        // short frame: in_last on k=4
        for (int i = 0; i < 5; i++) send(WW'($urandom), i == 4);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("short_err_pulse", frame_err, 1);
        @(negedge clk);
        check("short_err_clear", frame_err, 0);
        tick();
        idle(6);
        @(negedge clk);
        check("short_no_output", out_valid, 0);
        tick();
        for (int i = 0; i < N; i++) send(WW'($urandom), i == N - 1);
        idle(1);
        drain("drain_after_short");

        // both banks full with downstream stalled
        out_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(WW'(100 + i), (i % N) == N - 1);
        in_data = WW'(16'h5A5A);
        in_last = 1'b0;
        @(negedge clk);
        check("full_out_valid", out_valid, 1);
        check("full_out_index", out_index, 0);
        repeat (4) begin
            check("full_in_ready", in_ready, 0);
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(WW'(200 + i), i == N - 1);
        idle(1);
        drain("drain_three_frames");

        // reset mid-frame while an output is held
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(WW'($urandom) | WW'(1), i == N - 1);
        for (int i = 0; i < 5; i++) send(WW'($urandom), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_index", out_index, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(WW'($urandom), i == N - 1);
        idle(1);
        drain("drain_after_reset");

`ifdef FFT_REORDER_MAG_EN
        begin
            int n = 0;
            out_ready = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i == 0) send(16'h03FC, 1'b0);
                else if (i == 4) send(16'h8080, 1'b0);
                else send(16'h0000, i == N - 1);
            end
            in_valid = 1'b0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("mag_valid", out_valid, 1);
            check("mag_3_m4", out_data, 25);
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            @(negedge clk);
            check("mag_m128_m128", out_data, 32768);
            tick();
            out_ready = 1'b1;
            drain("drain_mag");
        end
`endif

        // randomized traffic with 50% out_ready
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    for (int k = 0; k < N; k++) begin
                        if ($urandom_range(0, 3) == 0) idle(1);
                        send(WW'($urandom), k == N - 1);
                    end
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
